elem_abssign_seq: RTL and testbench



---
 rtl/elem_abssign_seq_pkg.sv | 21 ++
 rtl/elem_abssign_seq_if.sv | 10 +
 rtl/elem_abssign_seq_abs_sign.sv | 24 ++
 rtl/elem_abssign_seq.sv | 122 ++++++++++++
 tb/tb_elem_abssign_seq.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/elem_abssign_seq_pkg.sv
// Shared matrix-library types and index helpers for the sequential abs/sign splitter.
package matlib_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } abssign_state_t;

   // Row-major flat index of 1-based element [row][col].
   function automatic int unsigned flat_idx(input int unsigned row,
                                            input int unsigned col,
                                            input int unsigned cols);
      return (row - 1) * cols + (col - 1);
   endfunction

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/elem_abssign_seq_if.sv
// fixedp: fixed-point format (WIDTH) plus the common clock and synchronous active-high reset.
interface fixedp #(
   parameter int WIDTH = 16
);
   logic clk;
   logic reset;

   modport master (output clk, output reset);
   modport slave  (input  clk, input  reset);
endinterface

// File: rtl/elem_abssign_seq_abs_sign.sv
// Combinational single-element magnitude/sign split.
// ELEM_ABSSIGN_SAT_EN: saturate |most-negative| to max positive instead of wrapping.
module abs_sign #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] mag,
   output logic             neg,
   output logic             ovf
);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   logic [WIDTH-1:0] neg_a;

   always_comb begin
      neg   = a[WIDTH-1];
      ovf   = (a == MIN_NEG);
      neg_a = ~a + 1'b1;
      mag   = neg ? neg_a : a;
`ifdef ELEM_ABSSIGN_SAT_EN
      if (ovf) mag = ~MIN_NEG;
`endif
   end
endmodule

// File: rtl/elem_abssign_seq.sv
// Sequential sign/magnitude split of a ROWS x COLS matrix, one element per cycle.
// ELEM_ABSSIGN_SAT_EN selects saturation of the most negative element (see abs_sign).
module elem_abssign_seq
   import matlib_pkg::*;
#(
   parameter int ROWS  = 1,
   parameter int COLS  = 1,
   parameter int WIDTH = 16   // element width; must equal g.WIDTH
) (
   fixedp.slave                              g,
   input  logic [ROWS:1][COLS:1][WIDTH-1:0] a,
   input  logic                              in_valid,
   output logic                              in_ready,
   output logic [ROWS:1][COLS:1][WIDTH-1:0] mag,
   output logic [ROWS:1][COLS:1][WIDTH-1:0] sgn,
   output logic                              ovf,
   output logic                              out_valid,
   input  logic                              out_ready
);
   localparam int N     = ROWS * COLS;
   localparam int IDX_W = idx_width(N);

   typedef logic [ROWS:1][COLS:1][WIDTH-1:0] mat_t;

   abssign_state_t   state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   mat_t             mat_q, mat_d;
   mat_t             mag_q, mag_d;
   mat_t             sgn_q, sgn_d;
   logic             ovf_q, ovf_d;

   logic [WIDTH-1:0] el_a, el_mag;
   logic             el_neg, el_ovf;
   logic             last;

   always_comb begin
      el_a = '0;
      for (int r = 1; r <= ROWS; r++) begin
         for (int c = 1; c <= COLS; c++) begin
            if (IDX_W'(flat_idx(r, c, COLS)) == idx_q) el_a = mat_q[r][c];
         end
      end
   end

   abs_sign #(.WIDTH(WIDTH)) u_abs_sign (
      .a   (el_a),
      .mag (el_mag),
      .neg (el_neg),
      .ovf (el_ovf)
   );

   assign last = (idx_q == IDX_W'(N - 1));

   // NOTE: every variable gets its hold value first so no path leaves one unassigned (no latches).
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      mat_d   = mat_q;
      mag_d   = mag_q;
      sgn_d   = sgn_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               mat_d   = a;
               idx_d   = '0;
               ovf_d   = 1'b0;
               state_d = RUN;
            end
         end
         RUN: begin
            for (int r = 1; r <= ROWS; r++) begin
               for (int c = 1; c <= COLS; c++) begin
                  if (IDX_W'(flat_idx(r, c, COLS)) == idx_q) begin
                     mag_d[r][c] = el_mag;
                     sgn_d[r][c] = {WIDTH{el_neg}};
                  end
               end
            end
            ovf_d = ovf_q | el_ovf;
            if (last) begin
               idx_d   = '0;
               state_d = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge g.clk) begin
      if (g.reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         mag_q   <= '0;
         sgn_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         mag_q   <= mag_d;
         sgn_q   <= sgn_d;
         ovf_q   <= ovf_d;
      end
   end

   // NOTE: the capture register is not reset; it is always reloaded on acceptance before any read.
   always_ff @(posedge g.clk) begin
      mat_q <= mat_d;
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign mag       = mag_q;
   assign sgn       = sgn_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_elem_abssign_seq.sv
// Self-checking bench for elem_abssign_seq: 2x2 and 1x1 instances against an arithmetic reference model.
module tb_elem_abssign_seq;

   typedef logic [2:1][2:1][15:0] mat_t;

`ifdef ELEM_ABSSIGN_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   fixedp #(.WIDTH(16)) g2 ();
   fixedp #(.WIDTH(16)) g1 ();
   assign g2.clk = clk;
   assign g1.clk = clk;

   mat_t a2, mag2, sgn2;
   logic in_valid2, in_ready2, ovf2, out_valid2, out_ready2;

   logic [1:1][1:1][15:0] a1, mag1, sgn1;
   logic in_valid1, in_ready1, ovf1, out_valid1, out_ready1;

   elem_abssign_seq #(.ROWS(2), .COLS(2), .WIDTH(16)) dut2 (
      .g(g2), .a(a2), .in_valid(in_valid2), .in_ready(in_ready2),
      .mag(mag2), .sgn(sgn2), .ovf(ovf2), .out_valid(out_valid2), .out_ready(out_ready2)
   );

   elem_abssign_seq #(.ROWS(1), .COLS(1), .WIDTH(16)) dut1 (
      .g(g1), .a(a1), .in_valid(in_valid1), .in_ready(in_ready1),
      .mag(mag1), .sgn(sgn1), .ovf(ovf1), .out_valid(out_valid1), .out_ready(out_ready1)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: plain signed arithmetic on each element.
   function automatic logic [15:0] ref_mag(input logic [15:0] v);
      int s;
      s = $signed(v);
      if (s == -32768) return SAT ? 16'h7FFF : 16'h8000;
      return 16'(s < 0 ? -s : s);
   endfunction

   function automatic logic [15:0] ref_sgn(input logic [15:0] v);
      int s;
      s = $signed(v);
      return (s < 0) ? 16'hFFFF : 16'h0000;
   endfunction

   function automatic logic [15:0] condneg(input logic [15:0] m, input logic c);
      int r;
      r = c ? -int'(m) : int'(m);
      return 16'(r);
   endfunction

   function automatic mat_t exp_mag(input mat_t m);
      mat_t e;
      for (int r = 1; r <= 2; r++) for (int c = 1; c <= 2; c++) e[r][c] = ref_mag(m[r][c]);
      return e;
   endfunction

   function automatic mat_t exp_sgn(input mat_t m);
      mat_t e;
      for (int r = 1; r <= 2; r++) for (int c = 1; c <= 2; c++) e[r][c] = ref_sgn(m[r][c]);
      return e;
   endfunction

   function automatic logic exp_ovf(input mat_t m);
      logic o = 1'b0;
      for (int r = 1; r <= 2; r++) for (int c = 1; c <= 2; c++) o |= (m[r][c] == 16'h8000);
      return o;
   endfunction

   function automatic mat_t rand_mat(input bit allow_min);
      mat_t m;
      logic [15:0] v;
      for (int r = 1; r <= 2; r++) begin
         for (int c = 1; c <= 2; c++) begin
            do v = 16'($urandom_range(0, 65535)); while (!allow_min && v == 16'h8000);
            m[r][c] = v;
         end
      end
      return m;
   endfunction

   // Called at a negedge with the 2x2 block idle; returns at the negedge where out_valid rises.
   task automatic send2(input mat_t m);
      int lat;
      check("accept_in_ready", 64'(in_ready2), 64'd1);
      a2 = m;
      in_valid2 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid2 = 1'b0;
      lat = 1;
      while (!out_valid2 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check("latency", 64'(lat), 64'd5);
   endtask

   task automatic check_result2(input mat_t m);
      check("mag", 64'(mag2), 64'(exp_mag(m)));
      check("sgn", 64'(sgn2), 64'(exp_sgn(m)));
      check("ovf", 64'(ovf2), 64'(exp_ovf(m)));
   endtask

   task automatic release2();
      out_ready2 = 1'b1;
      @(negedge clk);
      out_ready2 = 1'b0;
      check("release_out_valid", 64'(out_valid2), 64'd0);
      check("release_in_ready", 64'(in_ready2), 64'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

   initial begin
      mat_t m, held, rt;
      a2 = '0; in_valid2 = 1'b0; out_ready2 = 1'b0;
      a1 = '0; in_valid1 = 1'b0; out_ready1 = 1'b0;
      g2.reset = 1'b1;
      g1.reset = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_in_ready", 64'(in_ready2), 64'd1);
      check("rst_out_valid", 64'(out_valid2), 64'd0);
      check("rst_mag", 64'(mag2), 64'd0);
      check("rst_sgn", 64'(sgn2), 64'd0);
      check("rst_ovf", 64'(ovf2), 64'd0);
      g2.reset = 1'b0;
      g1.reset = 1'b0;

      // Positive/negative mix.
      m = '0;
      m[1][1] = 16'h0005; m[1][2] = 16'hFFFB; m[2][1] = 16'h0000; m[2][2] = 16'h7FFF;
      send2(m);
      check_result2(m);
      release2();

      // Most negative element.
      m[2][1] = 16'h8000;
      send2(m);
      check_result2(m);
      check("min_neg_mag", 64'(mag2[2][1]), SAT ? 64'h7FFF : 64'h8000);
      check("min_neg_sgn", 64'(sgn2[2][1]), 64'hFFFF);
      release2();

      // Backpressure: outputs hold and in_valid pulses are ignored while DONE.
      m = rand_mat(1'b1);
      send2(m);
      held = m;
      for (int i = 0; i < 10; i++) begin
         a2 = rand_mat(1'b1);
         in_valid2 = (i % 2 == 0);
         @(negedge clk);
         check("bp_out_valid", 64'(out_valid2), 64'd1);
         check("bp_in_ready", 64'(in_ready2), 64'd0);
         check("bp_mag", 64'(mag2), 64'(exp_mag(held)));
         check("bp_sgn", 64'(sgn2), 64'(exp_sgn(held)));
      end
      in_valid2 = 1'b0;
      check_result2(held);
      release2();

      // Reset in RUN cycle 2 with an overflow element already processed.
      m = '0;
      m[1][1] = 16'h8000; m[1][2] = 16'h1234; m[2][1] = 16'hF000; m[2][2] = 16'h0001;
      a2 = m;
      in_valid2 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid2 = 1'b0;
      @(negedge clk);
      g2.reset = 1'b1;
      @(negedge clk);
      g2.reset = 1'b0;
      check("midrst_out_valid", 64'(out_valid2), 64'd0);
      check("midrst_in_ready", 64'(in_ready2), 64'd1);
      check("midrst_mag", 64'(mag2), 64'd0);
      check("midrst_sgn", 64'(sgn2), 64'd0);
      check("midrst_ovf", 64'(ovf2), 64'd0);
      send2(m);
      check_result2(m);
      release2();

      // Random round trip through a conditional-negate model.
      for (int n = 0; n < 1000; n++) begin
         m = rand_mat(1'b0);
         send2(m);
         check_result2(m);
         for (int r = 1; r <= 2; r++)
            for (int c = 1; c <= 2; c++)
               rt[r][c] = condneg(mag2[r][c], sgn2[r][c][15]);
         check("round_trip", 64'(rt), 64'(m));
         release2();
      end

      // Random matrices that may contain the most negative value.
      for (int n = 0; n < 20; n++) begin
         m = rand_mat(1'b1);
         m[($urandom_range(0, 1)) + 1][($urandom_range(0, 1)) + 1] = 16'h8000;
         send2(m);
         check_result2(m);
         release2();
      end

      // 1x1 instance: RUN lasts one cycle.
      for (int n = 0; n < 3; n++) begin
         logic [15:0] v;
         v = (n == 0) ? 16'hFFFF : (n == 1) ? 16'h8000 : 16'h0000;
         check("s_in_ready", 64'(in_ready1), 64'd1);
         a1[1][1] = v;
         in_valid1 = 1'b1;
         @(posedge clk);
         @(negedge clk);
         in_valid1 = 1'b0;
         check("s_out_valid_c1", 64'(out_valid1), 64'd0);
         @(negedge clk);
         check("s_out_valid_c2", 64'(out_valid1), 64'd1);
         check("s_mag", 64'(mag1), 64'(ref_mag(v)));
         check("s_sgn", 64'(sgn1), 64'(ref_sgn(v)));
         check("s_ovf", 64'(ovf1), 64'(v == 16'h8000));
         out_ready1 = 1'b1;
         @(negedge clk);
         out_ready1 = 1'b0;
         check("s_release_in_ready", 64'(in_ready1), 64'd1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
